// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg
// Shared constants for the integer register file and its read-port bypass
// muxes.
//   XLEN     : register / data width
//   NREG     : number of architectural integer registers (x0..x31)
//   REG_AW   : register address width
//   REG_ZERO : address of the hard-wired zero register x0
//   isCommit : true when a write-back actually lands in the array
// ----------------------------------------------------------------------------
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int REG_AW = 5;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  // A write-back only counts as architectural when it is enabled and does not
  // target x0; the array, the commit counter and the snapshot all share this.
  function automatic logic isCommit(input logic we, input logic [REG_AW-1:0] addr);
    return we && (addr != REG_ZERO);
  endfunction

endpackage

// File: rtl/rf_bypass_mux.sv
// ----------------------------------------------------------------------------
// rf_bypass_mux
// One read port of the register file. Picks the architecturally current value
// of a register from the in-flight write-back value, the registered write, or
// the stored array word.
// Ports:
//   addr      in  read address
//   fwd_we    in  write enable of the instruction inside write-back
//   fwd_addr  in  its destination register
//   fwd_data  in  its value (same cycle)
//   wb_we     in  registered write enable
//   wb_addr   in  registered destination register
//   wb_data   in  registered write-back value
//   rf_word   in  array contents at addr
//   rd_data   out read data
// ----------------------------------------------------------------------------
module rf_bypass_mux
  import riscv_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [REG_AW-1:0] addr,
  input  logic              fwd_we,
  input  logic [REG_AW-1:0] fwd_addr,
  input  logic [DW-1:0]     fwd_data,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DW-1:0]     wb_data,
  input  logic [DW-1:0]     rf_word,
  output logic [DW-1:0]     rd_data
);

  // Priority from strongest to weakest: x0 always reads zero, then the
  // younger in-flight instruction, then the registered write that has not
  // reached the array yet, and finally the stored word.
  always_comb begin
    rd_data = rf_word;
    if (addr == REG_ZERO) begin
      rd_data = '0;
    end else if (fwd_we && (fwd_addr == addr)) begin
      rd_data = fwd_data;
    end else if (wb_we && (wb_addr == addr)) begin
      rd_data = wb_data;
    end
  end

endmodule

// File: rtl/reg_file_wb.sv
// ----------------------------------------------------------------------------
// reg_file_wb
// Integer register file terminating the write-back interface. Commits the
// registered write every rising clock edge, serves two bypassed combinational
// read ports, and keeps a committed-write counter plus last-write snapshot.
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   wb_we/wb_addr/wb_data registered write from write-back
//   fwd_we/fwd_addr/...   in-flight write-back instruction (not registered)
//   rs1_addr, rs2_addr    read addresses
//   rs1_data, rs2_data    bypassed read data
//   commit_cnt            count of committed writes to x1..x31 (wraps)
//   last_addr, last_data  destination and value of the latest commit
// ----------------------------------------------------------------------------
module reg_file_wb #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wb_we,
  input  logic [riscv_pkg::REG_AW-1:0] wb_addr,
  input  logic [XLEN-1:0]             wb_data,
  input  logic                        fwd_we,
  input  logic [riscv_pkg::REG_AW-1:0] fwd_addr,
  input  logic [XLEN-1:0]             fwd_data,
  input  logic [riscv_pkg::REG_AW-1:0] rs1_addr,
  input  logic [riscv_pkg::REG_AW-1:0] rs2_addr,
  output logic [XLEN-1:0]             rs1_data,
  output logic [XLEN-1:0]             rs2_data,
  output logic [31:0]                 commit_cnt,
  output logic [riscv_pkg::REG_AW-1:0] last_addr,
  output logic [XLEN-1:0]             last_data
);

  import riscv_pkg::*;

  logic [XLEN-1:0]   r_regs [NREG];
  logic [31:0]       r_commitCnt;
  logic [REG_AW-1:0] r_lastAddr;
  logic [XLEN-1:0]   r_lastData;

  logic              w_commit;
  logic [XLEN-1:0]   w_rs1Word;
  logic [XLEN-1:0]   w_rs2Word;

  assign w_commit  = isCommit(wb_we, wb_addr);
  assign w_rs1Word = r_regs[rs1_addr];
  assign w_rs2Word = r_regs[rs2_addr];

  // Array, commit counter and snapshot all advance together on a committed
  // write. x0 is never written, so its entry stays at the reset value of zero.
  // The counter is free-running modulo 2^32 with no overflow indication.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
      r_commitCnt <= '0;
      r_lastAddr  <= '0;
      r_lastData  <= '0;
    end else if (w_commit) begin
      r_regs[wb_addr] <= wb_data;
      r_commitCnt     <= r_commitCnt + 32'd1;
      r_lastAddr      <= wb_addr;
      r_lastData      <= wb_data;
    end
  end

  // Each read port gets its own bypass mux so the two ports resolve the same
  // address identically.
  rf_bypass_mux #(.DW(XLEN)) u_rs1Mux (
    .addr     (rs1_addr),
    .fwd_we   (fwd_we),
    .fwd_addr (fwd_addr),
    .fwd_data (fwd_data),
    .wb_we    (wb_we),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .rf_word  (w_rs1Word),
    .rd_data  (rs1_data)
  );

  rf_bypass_mux #(.DW(XLEN)) u_rs2Mux (
    .addr     (rs2_addr),
    .fwd_we   (fwd_we),
    .fwd_addr (fwd_addr),
    .fwd_data (fwd_data),
    .wb_we    (wb_we),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .rf_word  (w_rs2Word),
    .rd_data  (rs2_data)
  );

  assign commit_cnt = r_commitCnt;
  assign last_addr  = r_lastAddr;
  assign last_data  = r_lastData;

endmodule

// File: tb/tb_reg_file_wb.sv
// ----------------------------------------------------------------------------
// tb_reg_file_wb
// Self-checking bench for reg_file_wb: a table of directed vectors, a few
// hand-written multi-cycle sequences (counter wrap, reset mid-stream) and a
// randomized phase checked through a scoreboard against a reference model.
// ----------------------------------------------------------------------------
module tb_reg_file_wb;

  logic        clk;
  logic        reset;
  logic        wbWe;
  logic [4:0]  wbAddr;
  logic [31:0] wbData;
  logic        fwdWe;
  logic [4:0]  fwdAddr;
  logic [31:0] fwdData;
  logic [4:0]  rs1Addr;
  logic [4:0]  rs2Addr;
  logic [31:0] rs1Data;
  logic [31:0] rs2Data;
  logic [31:0] commitCnt;
  logic [4:0]  lastAddr;
  logic [31:0] lastData;

  int total = 0;
  int bad   = 0;

  reg_file_wb dut (
    .clk        (clk),
    .reset      (reset),
    .wb_we      (wbWe),
    .wb_addr    (wbAddr),
    .wb_data    (wbData),
    .fwd_we     (fwdWe),
    .fwd_addr   (fwdAddr),
    .fwd_data   (fwdData),
    .rs1_addr   (rs1Addr),
    .rs2_addr   (rs2Addr),
    .rs1_data   (rs1Data),
    .rs2_data   (rs2Data),
    .commit_cnt (commitCnt),
    .last_addr  (lastAddr),
    .last_data  (lastData)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        wbWe;
    logic [4:0]  wbAddr;
    logic [31:0] wbData;
    logic        fwdWe;
    logic [4:0]  fwdAddr;
    logic [31:0] fwdData;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] expRs1;
    logic [31:0] expRs2;
    logic [31:0] expCnt;
    logic [4:0]  expLastAddr;
    logic [31:0] expLastData;
  } vec_t;

  typedef struct {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] cnt;
    logic [4:0]  lastAddr;
    logic [31:0] lastData;
  } exp_t;

  vec_t vecs [12];
  exp_t sbQ [$];

  // Reference model of the architectural state.
  logic [31:0] mRegs [32];
  logic [31:0] mCnt;
  logic [4:0]  mLastAddr;
  logic [31:0] mLastData;

  // One comparison: counts it, and reports a FAIL line on a difference.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives every DUT input from one directed vector.
  task automatic applyStimulus(input vec_t v);
    wbWe    = v.wbWe;
    wbAddr  = v.wbAddr;
    wbData  = v.wbData;
    fwdWe   = v.fwdWe;
    fwdAddr = v.fwdAddr;
    fwdData = v.fwdData;
    rs1Addr = v.rs1;
    rs2Addr = v.rs2;
  endtask

  // Bypass-aware read of the reference model for the current inputs.
  function automatic logic [31:0] modelRead(input logic [4:0] a);
    if (a == 5'd0)                      return 32'd0;
    else if (fwdWe && (fwdAddr == a))   return fwdData;
    else if (wbWe && (wbAddr == a))     return wbData;
    else                                return mRegs[a];
  endfunction

  function automatic logic [4:0] pickAddr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    else                           return 5'($urandom_range(0, 7));
  endfunction

  task automatic modelClear();
    for (int k = 0; k < 32; k++) mRegs[k] = 32'd0;
    mCnt      = 32'd0;
    mLastAddr = 5'd0;
    mLastData = 32'd0;
  endtask

  task automatic modelCommit();
    if (wbWe && (wbAddr != 5'd0)) begin
      mRegs[wbAddr] = wbData;
      mCnt          = mCnt + 32'd1;
      mLastAddr     = wbAddr;
      mLastData     = wbData;
    end
  endtask

  // Main test sequence.
  initial begin
    exp_t e;
    exp_t got;
    logic rstNow;

    vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0, 32'h0,        5'd5,  5'd6,  32'hDEADBEEF, 32'h0,        32'd0, 5'd0,  32'h0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'd1, 5'd5,  32'hDEADBEEF};
    vecs[2]  = '{1'b1, 5'd0,  32'h1234,     1'b1, 5'd0, 32'h5555,     5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 32'd1, 5'd5,  32'hDEADBEEF};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,        5'd0,  5'd0,  32'h0,        32'h0,        32'd1, 5'd5,  32'hDEADBEEF};
    vecs[4]  = '{1'b1, 5'd7,  32'h11,       1'b0, 5'd0, 32'h0,        5'd7,  5'd7,  32'h11,       32'h11,       32'd1, 5'd5,  32'hDEADBEEF};
    vecs[5]  = '{1'b1, 5'd7,  32'h22,       1'b1, 5'd7, 32'h33,       5'd7,  5'd7,  32'h33,       32'h33,       32'd2, 5'd7,  32'h11};
    vecs[6]  = '{1'b1, 5'd7,  32'h22,       1'b0, 5'd0, 32'h0,        5'd7,  5'd7,  32'h22,       32'h22,       32'd3, 5'd7,  32'h22};
    vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,        5'd7,  5'd7,  32'h22,       32'h22,       32'd4, 5'd7,  32'h22};
    vecs[8]  = '{1'b1, 5'd10, 32'h0BAD,     1'b1, 5'd9, 32'hAAAA5555, 5'd9,  5'd10, 32'hAAAA5555, 32'h0BAD,     32'd4, 5'd7,  32'h22};
    vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,        5'd9,  5'd10, 32'h0,        32'h0BAD,     32'd5, 5'd10, 32'h0BAD};
    vecs[10] = '{1'b1, 5'd31, 32'h77770000, 1'b1, 5'd5, 32'h01020304, 5'd31, 5'd5,  32'h77770000, 32'h01020304, 32'd5, 5'd10, 32'h0BAD};
    vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,        5'd31, 5'd5,  32'h77770000, 32'hDEADBEEF, 32'd6, 5'd31, 32'h77770000};

    reset = 1'b0;
    wbWe = 1'b0; wbAddr = '0; wbData = '0;
    fwdWe = 1'b0; fwdAddr = '0; fwdData = '0;
    rs1Addr = '0; rs2Addr = '0;

    // Reset asserted before any clock edge must clear outputs at once.
    #1 reset = 1'b1;
    rs1Addr = 5'd1;
    rs2Addr = 5'd2;
    #1;
    checkOutput("reset_rs1", rs1Data, 32'd0);
    checkOutput("reset_rs2", rs2Data, 32'd0);
    checkOutput("reset_cnt", commitCnt, 32'd0);
    checkOutput("reset_last_addr", {27'd0, lastAddr}, 32'd0);
    checkOutput("reset_last_data", lastData, 32'd0);
    for (int a = 0; a < 32; a++) begin
      rs1Addr = 5'(a);
      rs2Addr = 5'(31 - a);
      #1;
      checkOutput("reset_sweep_rs1", rs1Data, 32'd0);
      checkOutput("reset_sweep_rs2", rs2Data, 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;

    // Directed table: each vector occupies one full clock cycle.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d_rs1", i), rs1Data, vecs[i].expRs1);
      checkOutput($sformatf("vec%0d_rs2", i), rs2Data, vecs[i].expRs2);
      checkOutput($sformatf("vec%0d_cnt", i), commitCnt, vecs[i].expCnt);
      checkOutput($sformatf("vec%0d_last_addr", i), {27'd0, lastAddr}, {27'd0, vecs[i].expLastAddr});
      checkOutput($sformatf("vec%0d_last_data", i), lastData, vecs[i].expLastData);
      @(posedge clk);
      @(negedge clk);
    end

    // Counter wrap: preload all ones, then one write to x3 must wrap to 0.
    wbWe = 1'b0; fwdWe = 1'b0;
    force dut.r_commitCnt = 32'hFFFF_FFFF;
    #1;
    checkOutput("wrap_preload", commitCnt, 32'hFFFF_FFFF);
    release dut.r_commitCnt;
    #1;
    checkOutput("wrap_held", commitCnt, 32'hFFFF_FFFF);
    wbWe = 1'b1; wbAddr = 5'd3; wbData = 32'h0ABC; rs1Addr = 5'd3;
    #1;
    checkOutput("wrap_bypass", rs1Data, 32'h0ABC);
    @(posedge clk);
    @(negedge clk);
    wbWe = 1'b0;
    #1;
    checkOutput("wrap_cnt", commitCnt, 32'd0);
    checkOutput("wrap_rs1", rs1Data, 32'h0ABC);
    checkOutput("wrap_last_addr", {27'd0, lastAddr}, 32'd3);

    // Reset between edges: state clears at once, bypass still applies,
    // and a write presented while reset is held is lost.
    @(negedge clk);
    wbWe = 1'b1; wbAddr = 5'd4; wbData = 32'h44;
    @(posedge clk);
    @(negedge clk);
    wbAddr = 5'd12; wbData = 32'h1212; rs1Addr = 5'd4; rs2Addr = 5'd12;
    #1;
    checkOutput("pre_rst_rs1", rs1Data, 32'h44);
    checkOutput("pre_rst_cnt", commitCnt, 32'd1);
    #1 reset = 1'b1;
    #1;
    checkOutput("mid_rst_rs1", rs1Data, 32'd0);
    checkOutput("mid_rst_rs2_bypass", rs2Data, 32'h1212);
    checkOutput("mid_rst_cnt", commitCnt, 32'd0);
    checkOutput("mid_rst_last_addr", {27'd0, lastAddr}, 32'd0);
    checkOutput("mid_rst_last_data", lastData, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    wbWe = 1'b0;
    #1;
    checkOutput("post_rst_rs2", rs2Data, 32'd0);
    checkOutput("post_rst_cnt", commitCnt, 32'd0);

    // Randomized phase with scoreboard against the reference model.
    modelClear();
    @(negedge clk);
    for (int i = 0; i < 10000; i++) begin
      rstNow  = ($urandom_range(0, 99) == 0);
      wbWe    = 1'($urandom_range(0, 1));
      wbAddr  = pickAddr();
      wbData  = $urandom;
      fwdWe   = 1'($urandom_range(0, 1));
      fwdAddr = pickAddr();
      fwdData = $urandom;
      rs1Addr = pickAddr();
      rs2Addr = ($urandom_range(0, 4) == 0) ? rs1Addr : pickAddr();
      if (rstNow) begin
        #2 reset = 1'b1;
        modelClear();
      end
      e.rs1      = modelRead(rs1Addr);
      e.rs2      = modelRead(rs2Addr);
      e.cnt      = mCnt;
      e.lastAddr = mLastAddr;
      e.lastData = mLastData;
      sbQ.push_back(e);
      #1;
      got = sbQ.pop_front();
      checkOutput("rand_rs1", rs1Data, got.rs1);
      checkOutput("rand_rs2", rs2Data, got.rs2);
      checkOutput("rand_cnt", commitCnt, got.cnt);
      checkOutput("rand_last_addr", {27'd0, lastAddr}, {27'd0, got.lastAddr});
      checkOutput("rand_last_data", lastData, got.lastData);
      @(posedge clk);
      if (!rstNow) modelCommit();
      @(negedge clk);
      reset = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file_wb.md
Name: reg_file_wb

Overview:
Integer register file (x0..x31) that terminates the write-back interface. It commits the registered write (RegWEn/AddrD/DataWB) each clock edge and serves two combinational read ports to decode. Each read port has a two-level bypass: the in-flight write-back value first, then the registered write. Read data is therefore always architecturally current, with no stall. It also keeps a committed-write counter and a last-write snapshot for debug/trace.

Parameters:
XLEN, 32, data width of registers and ports
NREG, 32, number of architectural registers; address width is clog2(NREG)=5

Ports:
clk  in  1  core clock, all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
wb_we  in  1  registered write enable from write-back stage
wb_addr  in  5  registered destination register
wb_data  in  XLEN  registered write-back value
fwd_we  in  1  write enable of the instruction currently inside the write-back stage (not yet registered)
fwd_addr  in  5  its destination register
fwd_data  in  XLEN  its combinationally selected value (same cycle)
rs1_addr  in  5  read port 1 address
rs2_addr  in  5  read port 2 address
rs1_data  out  XLEN  read port 1 data
rs2_data  out  XLEN  read port 2 data
commit_cnt  out  32  number of committed writes with addr != 0
last_addr  out  5  destination of the most recent committed write
last_data  out  XLEN  value of the most recent committed write

Behaviour:
- Reset (async, asserted): all 32 registers = 0, commit_cnt = 0, last_addr = 0, last_data = 0. Deassertion is synchronised externally. The block makes no assumption about reset release timing.
- Reset mid-operation: state clears at once. A write presented in the same cycle is lost. Read outputs reflect cleared state while reset is held; bypass sources still apply.
- Write: on posedge clk, if wb_we=1 and wb_addr!=0, regs[wb_addr] <= wb_data. Writes to x0 are discarded.
- Write latency: the array is updated 1 cycle after wb_* is valid. Bypass hides this latency.
- Read, per port p (combinational, zero latency), priority high to low:
  1. addr_p==0 -> 0, regardless of any bypass or write to x0.
  2. fwd_we=1 and fwd_addr==addr_p -> fwd_data. This is the younger instruction.
  3. wb_we=1 and wb_addr==addr_p -> wb_data.
  4. otherwise regs[addr_p].
- Same register on both ports: both ports return identical data.
- fwd and wb targeting the same register: fwd wins on reads. The array still receives wb_data this cycle, and fwd_data lands next cycle through the write-back stage.
- Counter: on each committed write (wb_we=1, wb_addr!=0), commit_cnt <= commit_cnt+1.
  - Modulo 2^32: 0xFFFF_FFFF wraps to 0, with no flag.
  - Writes to x0 do not count.
- Snapshot: on each committed write, last_addr/last_data load wb_addr/wb_data. Otherwise they hold.
- No X propagation: reads of any address are defined after reset.

Decomposition:
- Shared package (riscv_pkg):
  - XLEN, NREG, REG_AW=5
  - REG_ZERO = 5'd0
- Natural sub-module: rf_bypass_mux, one instance per read port. Inputs are addr, fwd_*, wb_* and the array word; output is read data, using the priority above.
- The array, counter and snapshot stay in the top.

Test Plan:
- Reset: assert reset with no clk edge -> rs1_data=rs2_data=0, commit_cnt=0, last_addr=0 immediately. Read all 32 addresses -> all 0.
- Write/read: wb_we=1, wb_addr=5, wb_data=0xDEADBEEF, one edge, then wb_we=0 and rs1_addr=5 -> rs1_data=0xDEADBEEF, commit_cnt=1, last_addr=5.
- x0 protection: wb_we=1, wb_addr=0, wb_data=0x1234; also fwd_we=1, fwd_addr=0; rs1_addr=0 -> rs1_data=0 before and after edge, commit_cnt unchanged.
- Bypass priority: regs[7]=0x11, wb_addr=7/wb_data=0x22, fwd_addr=7/fwd_data=0x33, rs1=rs2=7 -> both 0x33. Drop fwd_we -> 0x22. Edge, then drop wb_we -> 0x22 from the array.
- Counter wrap: preload commit_cnt to 0xFFFF_FFFF via 2^32-1 writes (or a force in the bench), then one write to x3 -> commit_cnt=0.
- Async reset mid-stream: back-to-back random writes, assert reset between edges -> all outputs 0 within the same cycle, no write committed at the next edge while reset=1. Scoreboard against a reference array model for 10k random cycles.
